// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op_code encodings (000 and 111 are NOP and need no name)
//   - FSM state encoding
//   - is_arith(): true for the four opcodes that run the iterative datapath
package muldiv_hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_iter_core.sv
// Radix-2 iterative datapath shared by multiply and divide.
// Holds {acc, q} plus the latched second operand b; one step per cycle.
//   Multiply (shift-add): q starts as the multiplier; after WIDTH steps
//     {acc, q} is the full unsigned product.
//   Divide (restoring): q starts as the dividend; after WIDTH steps
//     q is the quotient and acc the remainder. With b == 0 every trial
//     subtraction succeeds, so q ends all ones and acc ends equal to the
//     original dividend.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   load           latch a_in into q, b_in into b, clear acc
//   step           perform one iteration
//   mode_div       0 = multiply step, 1 = divide step
//   a_in, b_in     operand magnitudes
//   acc, q         current register contents (final results after WIDTH steps)
module muldiv_hilo_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply partial product: b gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = q_reg[0] & b_reg[gi];
        end
    endgenerate

    assign sum     = {1'b0, acc_reg} + {1'b0, addend};
    assign shifted = {acc_reg, q_reg[WIDTH-1]};
    // A full-width compare rather than the subtract borrow keeps b == 0
    // correct, where the partial remainder can exceed WIDTH bits.
    assign fits    = shifted >= {1'b0, b_reg};
    assign diff    = shifted[WIDTH-1:0] - b_reg;

    always_comb begin
        acc_next = acc_reg;
        q_next   = q_reg;
        if (load) begin
            acc_next = '0;
            q_next   = a_in;
        end else if (step) begin
            if (mode_div) begin
                acc_next = fits ? diff : shifted[WIDTH-1:0];
                q_next   = {q_reg[WIDTH-2:0], fits};
            end else begin
                acc_next = sum[WIDTH:1];
                q_next   = {sum[0], q_reg[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
            q_reg   <= '0;
            b_reg   <= '0;
        end else begin
            acc_reg <= acc_next;
            q_reg   <= q_next;
            if (load) begin
                b_reg <= b_in;
            end
        end
    end

    assign acc = acc_reg;
    assign q   = q_reg;

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MIPS-style multiply/divide unit with its own HI/LO pair.
// IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE. Signed operands are
// converted to magnitudes on acceptance; FIX restores the signs and commits.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   op_valid/op_ready   request handshake (ready only in IDLE)
//   op_code             operation (see muldiv_hilo_pkg)
//   src_a, src_b        operands / MTHI-MTLO data in src_a
//   flush               abort in-flight op or drop an op offered in IDLE
//   rd_sel, rd_data     combinational read: 0 = HI, 1 = LO
//   busy                arithmetic op in flight
//   done                one-cycle pulse after HI/LO commit
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;
    logic               is_div_reg, neg_lo_reg, neg_hi_reg;

    logic               accept, start_arith, commit;
    logic               op_signed, op_div, sign_a, sign_b, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   core_acc, core_q;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept      = op_valid && (state_reg == ST_IDLE) && !flush;
    assign start_arith = accept && is_arith(op_code);
    assign commit      = (state_reg == ST_FIX) && !flush;

    assign op_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign op_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign sign_a    = op_signed && src_a[WIDTH-1];
    assign sign_b    = op_signed && src_b[WIDTH-1];
    assign div_zero  = op_div && (src_b == '0);

    // Divide-by-zero feeds the raw dividend so HI ends up holding src_a
    // exactly as presented; the sign flags are cleared for that case.
    // The most-negative value negates to itself, which reads correctly as
    // the unsigned magnitude 2^(WIDTH-1).
    assign a_mag = (sign_a && !div_zero) ? (-src_a) : src_a;
    assign b_mag = sign_b ? (-src_b) : src_b;

    muldiv_hilo_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (start_arith),
        .step     (state_reg == ST_CALC),
        .mode_div (is_div_reg),
        .a_in     (a_mag),
        .b_in     (b_mag),
        .acc      (core_acc),
        .q        (core_q)
    );

    assign prod_mag = {core_acc, core_q};
    assign prod_fix = neg_lo_reg ? (-prod_mag) : prod_mag;
    assign quo_fix  = neg_lo_reg ? (-core_q) : core_q;
    assign rem_fix  = neg_hi_reg ? (-core_acc) : core_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_arith) state_next = ST_CALC;
            ST_CALC: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            is_div_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
        end else begin
            done_reg <= commit;
            if (start_arith) begin
                cnt_reg    <= '0;
                is_div_reg <= op_div;
                // Quotient (or product) sign vs. remainder sign (dividend's).
                neg_lo_reg <= (sign_a ^ sign_b) && !div_zero;
                neg_hi_reg <= op_div ? (sign_a && !div_zero) : (sign_a ^ sign_b);
            end else if (state_reg == ST_CALC) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (commit) begin
                if (is_div_reg) begin
                    hi_reg <= rem_fix;
                    lo_reg <= quo_fix;
                end else begin
                    {hi_reg, lo_reg} <= prod_fix;
                end
            end else if (accept && (op_code == OP_MTHI)) begin
                hi_reg <= src_a;
            end else if (accept && (op_code == OP_MTLO)) begin
                lo_reg <= src_a;
            end
        end
    end

    assign op_ready = (state_reg == ST_IDLE);
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign rd_data  = rd_sel ? lo_reg : hi_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_valid = 1'b0;
    logic [2:0]   op_code = 3'b000;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic         rd_sel = 1'b0;
    logic         op_ready, busy, done;
    logic [W-1:0] rd_data;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done)
    );

    // Reference results from native 64-bit arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   r;
        longint la, lb, lq, lr;
        logic [63:0] p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        r = '0;
        case (op)
            OP_MULT: begin
                p = 64'(la * lb);
                r = p;
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                r = p;
            end
            OP_DIV: begin
                if (b == '0) begin
                    r.hi = a; r.lo = '1;
                end else begin
                    lq = la / lb; lr = la % lb;
                    r.hi = lr[W-1:0]; r.lo = lq[W-1:0];
                end
            end
            default: begin
                if (b == '0) begin
                    r.hi = a; r.lo = '1;
                end else begin
                    r.hi = a % b; r.lo = a / b;
                end
            end
        endcase
        return r;
    endfunction

    // Stimulus: present an op now (called #1 after an edge), hold one edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 3'b000;
    endtask

    task automatic wait_done(output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        rd_sel = 1'b0; #1; hi = rd_data;
        rd_sel = 1'b1; #1; lo = rd_data;
    endtask

    task automatic test_reset();
        logic [W-1:0] hi, lo;
        rst_n = 1'b0;
        #12;
        read_hilo(hi, lo);
        n_checks += 5;
        if (hi !== '0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        if (lo !== '0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t tbl[9];
        int   bc;
        bit   to;
        exp_t e;
        logic [W-1:0] hi, lo;
        tbl[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1] = '{OP_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[2] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        tbl[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[4] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        tbl[5] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        tbl[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back('{hi: tbl[i].hi, lo: tbl[i].lo});
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_done(bc, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL dir%0d_timeout got=no_done exp=done", i); end
            n_checks++;
            if (bc !== 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bc); end
            e = sb_q.pop_front();
            read_hilo(hi, lo);
            $display("txn op=%0d a=%h b=%h hi=%h lo=%h", tbl[i].op, tbl[i].a, tbl[i].b, hi, lo);
            n_checks += 2;
            if (hi !== e.hi) begin n_fail++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, e.hi); end
            if (lo !== e.lo) begin n_fail++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, e.lo); end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_back_to_back();
        int   bc;
        bit   to;
        exp_t e;
        logic [2:0]   op;
        logic [W-1:0] a, b, hi, lo;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom();
            b  = (i == 5) ? 32'd0 : $urandom() >> $urandom_range(0, 28);
            sb_q.push_back(model(op, a, b));
            issue(op, a, b);
            wait_done(bc, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL rnd%0d_timeout got=no_done exp=done", i); end
            e = sb_q.pop_front();
            read_hilo(hi, lo);
            $display("txn op=%0d a=%h b=%h hi=%h lo=%h", op, a, b, hi, lo);
            n_checks += 2;
            if (hi !== e.hi) begin n_fail++; $display("FAIL rnd%0d_hi got=%h exp=%h", i, hi, e.hi); end
            if (lo !== e.lo) begin n_fail++; $display("FAIL rnd%0d_lo got=%h exp=%h", i, lo, e.lo); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mthi_mtlo();
        logic [W-1:0] hi, lo;
        issue(OP_MTHI, 32'h00001234, 32'd0);
        issue(OP_MTLO, 32'h00005678, 32'd0);
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mt_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL mt_done got=%b exp=0", done); end
        issue(3'b000, 32'hFFFFFFFF, 32'd1);
        issue(3'b111, 32'hFFFFFFFF, 32'd1);
        read_hilo(hi, lo);
        $display("txn mthi/mtlo/nop hi=%h lo=%h", hi, lo);
        n_checks += 3;
        if (hi !== 32'h1234) begin n_fail++; $display("FAIL mt_hi got=%h exp=00001234", hi); end
        if (lo !== 32'h5678) begin n_fail++; $display("FAIL mt_lo got=%h exp=00005678", lo); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush();
        logic [W-1:0] hi, lo;
        bit saw_done;
        issue(OP_MTHI, 32'h00001234, 32'd0);
        issue(OP_MTLO, 32'h00005678, 32'd0);
        // Abort in CALC.
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done got=%b exp=0", done); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_late_done got=1 exp=0"); end
        read_hilo(hi, lo);
        $display("txn flush_calc hi=%h lo=%h", hi, lo);
        n_checks += 2;
        if (hi !== 32'h1234) begin n_fail++; $display("FAIL flush_hi got=%h exp=00001234", hi); end
        if (lo !== 32'h5678) begin n_fail++; $display("FAIL flush_lo got=%h exp=00005678", lo); end
        // Abort in FIX: 32 CALC edges after acceptance puts the FSM in FIX.
        issue(OP_MULTU, 32'd3, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        read_hilo(hi, lo);
        $display("txn flush_fix hi=%h lo=%h", hi, lo);
        n_checks += 3;
        if (done !== 1'b0) begin n_fail++; $display("FAIL flushfix_done got=%b exp=0", done); end
        if (hi !== 32'h1234) begin n_fail++; $display("FAIL flushfix_hi got=%h exp=00001234", hi); end
        if (lo !== 32'h5678) begin n_fail++; $display("FAIL flushfix_lo got=%h exp=00005678", lo); end
        // Flush in IDLE drops the offered op.
        flush = 1'b1;
        issue(OP_MTHI, 32'h0000DEAD, 32'd0);
        issue(OP_MULT, 32'd2, 32'd2);
        flush = 1'b0;
        read_hilo(hi, lo);
        $display("txn flush_idle hi=%h lo=%h", hi, lo);
        n_checks += 2;
        if (hi !== 32'h1234) begin n_fail++; $display("FAIL flushidle_hi got=%h exp=00001234", hi); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flushidle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_busy_hold();
        int   stalls;
        exp_t e;
        logic [W-1:0] hi, lo;
        sb_q.push_back(model(OP_MULTU, 32'd3, 32'd5));
        issue(OP_MULTU, 32'd3, 32'd5);
        op_valid = 1'b1; op_code = OP_MTLO; src_a = 32'h0000CAFE;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            if (op_ready === 1'b1) break;
            stalls++;
            @(posedge clk); #1;
        end
        n_checks += 2;
        if (stalls !== 33) begin n_fail++; $display("FAIL hold_stalls got=%0d exp=33", stalls); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done got=%b exp=1", done); end
        e = sb_q.pop_front();
        read_hilo(hi, lo);
        n_checks += 2;
        if (hi !== e.hi) begin n_fail++; $display("FAIL hold_mul_hi got=%h exp=%h", hi, e.hi); end
        if (lo !== e.lo) begin n_fail++; $display("FAIL hold_mul_lo got=%h exp=%h", lo, e.lo); end
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 3'b000;
        read_hilo(hi, lo);
        $display("txn held_mtlo hi=%h lo=%h", hi, lo);
        n_checks += 3;
        if (hi !== 32'd0) begin n_fail++; $display("FAIL hold_hi got=%h exp=00000000", hi); end
        if (lo !== 32'hCAFE) begin n_fail++; $display("FAIL hold_lo got=%h exp=0000cafe", lo); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] hi, lo;
        issue(OP_MTHI, 32'h0000AAAA, 32'd0);
        issue(OP_MTLO, 32'h0000BBBB, 32'd0);
        issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", op_ready); end
        read_hilo(hi, lo);
        $display("txn reset_mid hi=%h lo=%h", hi, lo);
        n_checks += 2;
        if (hi !== '0) begin n_fail++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        if (lo !== '0) begin n_fail++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        read_hilo(hi, lo);
        n_checks += 3;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done); end
        if (hi !== '0) begin n_fail++; $display("FAIL rstmid_hi_after got=%h exp=0", hi); end
        if (lo !== '0) begin n_fail++; $display("FAIL rstmid_lo_after got=%h exp=0", lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mthi_mtlo();
        test_flush();
        test_busy_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
